ovl_increment_multi: RTL and testbench
======================================

# ovl_increment_multi

Multi-channel, parametrised increment checker for the OVL semantic suite, generalising the single-channel fixed-step increment check. Each channel watches one `width`-bit expression and flags any change whose modular delta falls outside `[min_inc, max_inc]`. Wrap-around is selectable per instance. Per-channel violation pulses, an OR-reduced flag and an optional saturating error counter feed the semantic wrappers' pass/fail harnesses.

## Interface
Clock/reset: one clock; reset is asynchronous and active-high (ports named `clock`, `reset`).

Parameters:
- `width`, 4: bits per channel expression (≥2).
- `channels`, 2: number of independent channels (≥1).
- `min_inc`, 1: smallest legal increment (≥1).
- `max_inc`, 1: largest legal increment (≥`min_inc`, <2^`width`).
- `wrap_mode`, 0: 0 = a new value numerically below the previous one is a violation; 1 = modular wrap is legal if the modular delta is in range.

Ports:
- `clock` input 1: sampling clock, rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `enable` input 1: global check enable.
- `test_expr` input `channels*width`: channel k occupies bits `[k*width +: width]`.
- `fire` output `channels`: per-channel violation pulse, registered.
- `fire_any` output 1: registered OR of `fire`.
- `err_count` output 16: saturating violation count.

## Operation
- Per-channel state: `prev[width]` and `armed`. `armed=0` is UNARMED, `armed=1` is ARMED.
- Each rising edge with `enable=1`, per channel:
  - UNARMED: `prev<=test_expr`, `armed<=1`. No check.
  - ARMED, `test_expr==prev`: no check. `prev` is unchanged.
  - ARMED, `test_expr!=prev`: compute `delta=(test_expr-prev) mod 2^width` in `width` bits.
    - Violation if `delta<min_inc` or `delta>max_inc`.
    - Also a violation if `wrap_mode==0` and `test_expr<prev` (unsigned compare).
    - `prev<=test_expr` whether or not a violation occurs.
- Edge with `enable=0`: every channel goes to UNARMED (`armed<=0`). `prev` holds. No checks. `fire` is cleared next edge.
- Channels are fully independent. Simultaneous violations on multiple channels are all reported in the same cycle.
- `err_count` adds the popcount of this cycle's violations. It saturates at 16'hFFFF and never wraps. `min(count+popcount, 16'hFFFF)` is computed in 17+ bits.
- Reset (async assert, any time, including mid-sequence):
  - `armed=0`, `prev=0`, `fire=0`, `fire_any=0`, `err_count=0`.
  - The first enabled edge after release only arms the channel.

## Timing
- Sample on edge N yields `fire`/`fire_any` on edge N (visible after N, until N+1). Latency is 1 cycle from the `test_expr` value to the flag.
- `fire` is a single-cycle pulse per violating sample. Consecutive violating samples give consecutive pulses.
- `err_count` updates on the same edge as `fire`.
- After reset deasserts:
  - Earliest possible `fire` is on the second enabled edge.
  - The first enabled edge arms; the second checks.
- `enable` low for a single edge forces a re-arm. The next enabled edge never fires.

## Configuration
- `OVL_INCR_ERR_COUNT_EN` defined: `err_count` logic built as above.
- `OVL_INCR_ERR_COUNT_EN` undefined: `err_count` is tied to 16'h0000 and no counter flops exist. `fire`/`fire_any` behaviour is unchanged.

## Test plan
1. Increment by `min_inc`, then an unchanged sample. Config: `width=4`, `channels=1`, `min_inc=max_inc=1`. ch0 0→0→1→1.
   - Required: `fire` never asserts; `err_count=0`.
2. Step of 2 with a fixed step of 1. Same config as scenario 1, ch0 0→2.
   - Required: `fire[0]=1` for exactly one cycle, on the edge that samples 2.
   - Required: `err_count=1`; `fire_any=1` for that cycle.
3. Wrap 15→0, `min_inc=max_inc=1`.
   - `wrap_mode=1`: no fire.
   - `wrap_mode=0`: one `fire` pulse; `err_count=1`.
4. Range with two channels. Config: `channels=2`, `min_inc=1`, `max_inc=3`.
   - ch0 4→7: legal.
   - ch1 4→8 on the same edge: `fire=2'b10`.
   - Next edge, ch0 7→6 and ch1 8→6 (both decrements): `fire=2'b11`; `err_count=3`.
5. Re-arm and reset. ch0 armed at 3.
   - Drop `enable` one cycle, then ch0 jumps to 9: no fire.
   - Then assert `reset` asynchronously mid-cycle: `fire`, `err_count` and `armed` clear immediately.
   - The first post-reset enabled sample (any value) does not fire.
6. Saturation, with `OVL_INCR_ERR_COUNT_EN` defined.
   - Force 65,536 violating samples: `err_count` holds at 16'hFFFF.
   - Rebuild without the macro: `err_count` stays 0 while `fire` pulses identically.

Source files
------------

// File: rtl/ovl_increment_multi.sv
// Multi-channel increment checker: flags any change of a channel expression whose
// modular delta lies outside [min_inc, max_inc]. Optional counter: OVL_INCR_ERR_COUNT_EN.
module ovl_increment_multi #(
    parameter int width     = 4,
    parameter int channels  = 2,
    parameter int min_inc   = 1,
    parameter int max_inc   = 1,
    parameter int wrap_mode = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [channels*width-1:0]   test_expr,
    output logic [channels-1:0]         fire,
    output logic                        fire_any,
    output logic [15:0]                 err_count
);

    localparam logic [width-1:0] MIN_L = width'(min_inc);
    localparam logic [width-1:0] MAX_L = width'(max_inc);

    logic [channels-1:0][width-1:0] prev;
    logic [channels-1:0]            armed;
    logic [channels-1:0]            viol;
    logic [width-1:0]               cur;
    logic [width-1:0]               delta;

    // Only an armed channel whose value actually changed is checked.
    always_comb begin
        viol  = '0;
        cur   = '0;
        delta = '0;
        for (int k = 0; k < channels; k++) begin
            cur   = test_expr[k*width +: width];
            delta = cur - prev[k];
            if (enable && armed[k] && (cur != prev[k])) begin
                viol[k] = (delta < MIN_L) || (delta > MAX_L) ||
                          ((wrap_mode == 0) && (cur < prev[k]));
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev     <= '0;
            armed    <= '0;
            fire     <= '0;
            fire_any <= 1'b0;
        end else begin
            if (enable) begin
                prev  <= test_expr;
                armed <= '1;
            end else begin
                armed <= '0;
            end
            fire     <= viol;
            fire_any <= |viol;
        end
    end

`ifdef OVL_INCR_ERR_COUNT_EN
    logic [16:0] pop;
    logic [16:0] sum;

    // Sum kept one bit wider than the counter so saturation is detected, not wrapped.
    always_comb begin
        pop = '0;
        for (int k = 0; k < channels; k++) begin
            pop = pop + 17'(viol[k]);
        end
        sum = {1'b0, err_count} + pop;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_count <= '0;
        end else begin
            err_count <= sum[16] ? 16'hFFFF : sum[15:0];
        end
    end
`else
    assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_ovl_increment_multi.sv
// Self-checking bench for ovl_increment_multi: two instances (ranged/no-wrap and
// fixed-step/wrap) driven in lockstep and compared against a delta-rule model.
module tb_ovl_increment_multi;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  expr_a;
    logic [3:0]  expr_b;
    logic [1:0]  fire_a;
    logic        fire_any_a;
    logic [15:0] err_a;
    logic [0:0]  fire_b;
    logic        fire_any_b;
    logic [15:0] err_b;

    int checks = 0;
    int errors = 0;

    int prev_a[2];
    int armed_a[2];
    int cnt_a;
    bit [1:0] exp_fire_a;
    int prev_b;
    int armed_b;
    int cnt_b;
    bit exp_fire_b;

    ovl_increment_multi #(.width(4), .channels(2), .min_inc(1), .max_inc(3), .wrap_mode(0)) dut_a (
        .clock(clock), .reset(reset), .enable(enable), .test_expr(expr_a),
        .fire(fire_a), .fire_any(fire_any_a), .err_count(err_a)
    );

    ovl_increment_multi #(.width(4), .channels(1), .min_inc(1), .max_inc(1), .wrap_mode(1)) dut_b (
        .clock(clock), .reset(reset), .enable(enable), .test_expr(expr_b),
        .fire(fire_b), .fire_any(fire_any_b), .err_count(err_b)
    );

    always #5 clock = ~clock;

    function automatic bit isViol(int cur, int prv, int mn, int mx, int wrap);
        int d;
        d = (cur - prv + 16) % 16;
        return (cur != prv) && ((d < mn) || (d > mx) || ((wrap == 0) && (cur < prv)));
    endfunction

    function automatic int satAdd(int c, int p);
        return (c + p > 65535) ? 65535 : c + p;
    endfunction

    function automatic int expCount(int c);
`ifdef OVL_INCR_ERR_COUNT_EN
        return c;
`else
        return 0;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int c = 0; c < 2; c++) begin
            prev_a[c]  = 0;
            armed_a[c] = 0;
        end
        cnt_a = 0; exp_fire_a = '0;
        prev_b = 0; armed_b = 0; cnt_b = 0; exp_fire_b = 1'b0;
    endtask

    task automatic compareAll();
        checkOutput("fire_a",     32'(fire_a),     32'(exp_fire_a));
        checkOutput("fire_any_a", 32'(fire_any_a), 32'(|exp_fire_a));
        checkOutput("err_a",      32'(err_a),      32'(expCount(cnt_a)));
        checkOutput("fire_b",     32'(fire_b),     32'(exp_fire_b));
        checkOutput("fire_any_b", 32'(fire_any_b), 32'(exp_fire_b));
        checkOutput("err_b",      32'(err_b),      32'(expCount(cnt_b)));
    endtask

    task automatic applyStimulus(input bit en, input logic [7:0] a, input logic [3:0] b, input bit chk);
        int pop;
        int cur;
        enable = en;
        expr_a = a;
        expr_b = b;
        @(posedge clock);
        pop = 0;
        for (int c = 0; c < 2; c++) begin
            cur = int'(a[c*4 +: 4]);
            exp_fire_a[c] = 1'b0;
            if (en) begin
                if (armed_a[c] != 0) exp_fire_a[c] = isViol(cur, prev_a[c], 1, 3, 0);
                prev_a[c]  = cur;
                armed_a[c] = 1;
            end else begin
                armed_a[c] = 0;
            end
            pop += int'(exp_fire_a[c]);
        end
        cnt_a = satAdd(cnt_a, pop);
        exp_fire_b = 1'b0;
        if (en) begin
            if (armed_b != 0) exp_fire_b = isViol(int'(b), prev_b, 1, 1, 1);
            prev_b  = int'(b);
            armed_b = 1;
        end else begin
            armed_b = 0;
        end
        cnt_b = satAdd(cnt_b, int'(exp_fire_b));
        #1;
        if (chk) compareAll();
    endtask

    initial begin
        logic [3:0] n0, n1, nb;
        reset  = 1'b1;
        enable = 1'b0;
        expr_a = '0;
        expr_b = '0;
        modelReset();
        #12;
        compareAll();
        reset = 1'b0;

        // Directed: arm, unchanged, ranged steps, fixed-step violation, wraps.
        applyStimulus(1, 8'h44, 4'd0, 1);
        applyStimulus(1, 8'h44, 4'd0, 1);
        applyStimulus(1, 8'h87, 4'd1, 1);
        checkOutput("plan_fire_10", 32'(fire_a), 32'h2);
        applyStimulus(1, 8'h66, 4'd1, 1);
        checkOutput("plan_fire_11", 32'(fire_a), 32'h3);
        checkOutput("plan_err_3", 32'(err_a), 32'(expCount(3)));
        applyStimulus(1, 8'h66, 4'd3, 1);
        checkOutput("plan_step2", 32'(fire_b), 32'h1);
        applyStimulus(1, 8'h69, 4'd3, 1);
        applyStimulus(1, 8'h6C, 4'd15, 1);
        applyStimulus(1, 8'h6F, 4'd0, 1);
        checkOutput("plan_wrap_ok", 32'(fire_b), 32'h0);
        applyStimulus(1, 8'h60, 4'd1, 1);
        checkOutput("plan_wrap_viol", 32'(fire_a), 32'h1);

        // Re-arm after a single disabled edge, then an asynchronous mid-cycle reset.
        applyStimulus(1, 8'h63, 4'd2, 1);
        applyStimulus(0, 8'h63, 4'd2, 1);
        applyStimulus(1, 8'h69, 4'd9, 1);
        checkOutput("plan_rearm", 32'(fire_a), 32'h0);
        applyStimulus(1, 8'h6F, 4'd14, 1);
        #2 reset = 1'b1;
        #1;
        modelReset();
        compareAll();
        #2 reset = 1'b0;
        applyStimulus(1, 8'hA5, 4'd7, 1);
        checkOutput("plan_post_reset", 32'({fire_a, fire_b}), 32'h0);

        // Randomised small deltas, occasional arbitrary jumps and disabled edges.
        for (int i = 0; i < 400; i++) begin
            n0 = 4'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : (prev_a[0] + $urandom_range(0, 4)) % 16);
            n1 = 4'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : (prev_a[1] + 15 + $urandom_range(0, 5)) % 16);
            nb = 4'((prev_b + $urandom_range(0, 2)) % 16);
            applyStimulus($urandom_range(0, 9) != 0, {n1, n0}, nb, 1);
        end

        // Saturation: both channels violate on every edge.
        for (int i = 0; i < 33000; i++) begin
            applyStimulus(1, (i % 2 == 0) ? 8'h88 : 8'h00, (i % 2 == 0) ? 4'd2 : 4'd0, (i % 1024) == 0);
        end
        compareAll();
        checkOutput("plan_saturate", 32'(err_a), 32'(expCount(65535)));
        checkOutput("plan_sat_fire", 32'(fire_a), 32'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
